cc_feeder: RTL and testbench
============================

CC_FEEDER -- requirements
Module: cc_feeder

Interface
REQ-001 SHALL have no parameters; block size is fixed at 64 bytes (16 x 32-bit words).
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_rstn  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  one-cycle message start pulse; honoured in IDLE only.
REQ-005 i_key  in  256  key; sampled when i_start is honoured.
REQ-006 i_non  in  96  nonce; sampled when i_start is honoured.
REQ-007 i_len  in  32  message length in bytes; sampled when i_start is honoured.
REQ-008 i_valid / i_data  in  1 / 32  plaintext word stream; transfer when i_valid and o_ready are both high.
REQ-009 o_ready  out  1  feeder accepts a plaintext word this cycle.
REQ-010 o_start, o_en_pt  out  1 each  one-cycle pulses to the encryption engine.
REQ-011 o_key, o_non, o_pt, o_len_pt  out  256, 96, 512, 32  engine operands.
REQ-012 i_rqst_pt, i_done  in  1 each  engine requests next block / engine finished.
REQ-013 i_ct  in  512  engine output block; valid in any cycle where i_rqst_pt or i_done is high.
REQ-014 o_otk  out  256  one-time Poly1305 key, i.e. i_ct[511:256] of the first engine block.
REQ-015 o_ct_valid, o_ct_data, o_ct_last, o_ct_keep  out  1, 32, 1, 4  ciphertext word stream; i_ct_ready  in  1  sink backpressure.
REQ-016 o_busy, o_done  out  1 each  message in progress / one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, START, OTK, LOAD, FEED, WAIT, DRAIN, DONE.
REQ-018 IDLE->START on i_start: latch key/nonce/len; set rem_bytes=i_len; clear the 16-word assembly buffer.
REQ-019 START SHALL pulse o_start for one cycle with o_pt=0, o_len_pt=latched length, then go to OTK.
REQ-020 OTK: on i_rqst_pt or i_done, capture o_otk. If rem_bytes==0, go to DONE; otherwise go to LOAD.
REQ-021 LOAD SHALL raise o_ready until min(16, ceil(rem_bytes/4)) words are accepted. Word k (0-based) SHALL be placed at o_pt[511-32k -: 32]. Unfilled words SHALL be zero.
REQ-022 LOAD->FEED SHALL occur only when the block is complete and the output serializer is empty.
REQ-023 FEED SHALL pulse o_en_pt for one cycle with the assembled o_pt, then go to WAIT.
REQ-024 WAIT: on i_rqst_pt or i_done, load i_ct into the serializer with count=min(64, rem_bytes); rem_bytes -= count (saturating at 0).
REQ-025 WAIT->LOAD if i_rqst_pt and rem_bytes>0 after the update; WAIT->DRAIN if i_done; otherwise stay in WAIT.
REQ-026 Serializer SHALL emit words MSW first, one per cycle while i_ct_ready is high; o_ct_data and o_ct_valid SHALL hold stable while stalled.
REQ-027 o_ct_keep SHALL be 4'b1111 except on the final message word, where it holds the valid bytes MSB-first (e.g. 2 bytes -> 4'b1100).
REQ-028 o_ct_last SHALL assert on the final word of the message only.
REQ-029 LOAD SHALL accept plaintext words while the serializer drains (overlap is permitted). FEED SHALL wait for the drain to finish.
REQ-030 DRAIN->DONE when the serializer is empty. DONE SHALL pulse o_done for one cycle, then return to IDLE.
REQ-031 o_busy SHALL be high in every state except IDLE.
REQ-032 i_start outside IDLE SHALL be ignored.
REQ-033 i_rqst_pt and i_done outside OTK/WAIT SHALL be ignored.
REQ-034 i_rqst_pt and i_done high in the same cycle SHALL be treated as i_done.
REQ-035 Byte counters SHALL be 32-bit; i_len=32'hFFFFFFFF SHALL not overflow any count.

Reset
REQ-036 On i_rstn low, state SHALL be IDLE and all outputs and registers SHALL be zero, including o_otk and o_pt.
REQ-037 Reset asserted mid-message SHALL abort the message with no further o_ct_valid, o_en_pt or o_done.

Verification
REQ-038 i_len=0 -> one o_start; after i_rqst_pt, o_otk=i_ct[511:256]; no o_ct_valid; o_done one cycle later.
REQ-039 i_len=64, 16 words 0..15 -> o_en_pt once with o_pt[511:480]=0; 16 ct words; o_ct_last and keep=1111 on word 15.
REQ-040 i_len=70 -> two blocks; second o_pt holds 2 data words then 14 zero words; 18 ct words; last word keep=4'b1100.
REQ-041 i_ct_ready held low for 40 cycles mid-block -> no o_en_pt until drain completes; data is held stable; no words are lost.
REQ-042 i_start re-pulsed while busy -> ignored; second message then runs correctly after o_done.
REQ-043 Reset in WAIT of a 3-block message -> all outputs zero immediately; a fresh message afterwards completes normally.

Source files
------------

// File: rtl/cc_feeder.sv
// Plaintext/ciphertext feeder for a 64-byte-block stream cipher engine: assembles
// plaintext words into blocks, sequences the engine, and serializes its output blocks.
module cc_feeder (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic [255:0] i_key,
    input  logic [95:0]  i_non,
    input  logic [31:0]  i_len,
    input  logic         i_valid,
    input  logic [31:0]  i_data,
    output logic         o_ready,
    output logic         o_start,
    output logic         o_en_pt,
    output logic [255:0] o_key,
    output logic [95:0]  o_non,
    output logic [511:0] o_pt,
    output logic [31:0]  o_len_pt,
    input  logic         i_rqst_pt,
    input  logic         i_done,
    input  logic [511:0] i_ct,
    output logic [255:0] o_otk,
    output logic         o_ct_valid,
    output logic [31:0]  o_ct_data,
    output logic         o_ct_last,
    output logic [3:0]   o_ct_keep,
    input  logic         i_ct_ready,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic [2:0] {IDLE, START, OTK, LOAD, FEED, WAIT, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [31:0]  rem_bytes;
    logic [4:0]   wcnt;
    logic [4:0]   need_words;
    logic [511:0] ser_buf;
    logic [4:0]   ser_words;
    logic [6:0]   ser_bytes;
    logic         ser_final;
    logic         eng_evt;
    logic [6:0]   blk_bytes;
    logic [4:0]   blk_words;
    logic [31:0]  rem_after;
    logic         block_full;
    logic         ser_empty;
    logic         ser_load;
    logic         ct_xfer;
    logic         in_xfer;
    logic         enter_load;

    assign eng_evt    = i_rqst_pt | i_done;
    assign blk_bytes  = (rem_bytes >= 32'd64) ? 7'd64 : rem_bytes[6:0];
    assign blk_words  = blk_bytes[6:2] + {4'd0, |blk_bytes[1:0]};
    assign rem_after  = rem_bytes - {25'd0, blk_bytes};
    // ceil(rem/4) without forming rem+3, which would wrap for lengths near 2^32
    assign need_words = (rem_bytes >= 32'd64) ? 5'd16
                      : {1'b0, rem_bytes[5:2]} + {4'd0, |rem_bytes[1:0]};
    assign block_full = (wcnt == need_words);
    assign ser_empty  = (ser_words == 5'd0);
    // A zero-byte load (engine done after the last block) must not clobber a draining block
    assign ser_load   = (state == WAIT) && eng_evt && (rem_bytes != 32'd0);
    assign enter_load = (state_nxt == LOAD) && (state != LOAD);

    assign o_ready    = (state == LOAD) && !block_full;
    assign in_xfer    = i_valid && o_ready;
    assign o_ct_valid = !ser_empty;
    assign o_ct_data  = ser_buf[511:480];
    assign o_ct_last  = ser_final && (ser_words == 5'd1);
    assign ct_xfer    = o_ct_valid && i_ct_ready;

    always_comb begin
        o_ct_keep = 4'b0000;
        if (o_ct_valid) begin
            o_ct_keep = 4'b1111;
            if (o_ct_last) begin
                case (ser_bytes)
                    7'd1:    o_ct_keep = 4'b1000;
                    7'd2:    o_ct_keep = 4'b1100;
                    7'd3:    o_ct_keep = 4'b1110;
                    default: o_ct_keep = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_start   = 1'b0;
        o_en_pt   = 1'b0;
        o_done    = 1'b0;
        o_busy    = (state != IDLE);
        case (state)
            IDLE:  if (i_start) state_nxt = START;
            START: begin
                o_start   = 1'b1;
                state_nxt = OTK;
            end
            OTK:   if (eng_evt) state_nxt = (rem_bytes == 32'd0) ? DONE : LOAD;
            LOAD:  if (block_full && ser_empty) state_nxt = FEED;
            FEED:  begin
                o_en_pt   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  begin
                if (i_done)                                   state_nxt = DRAIN;
                else if (i_rqst_pt && (rem_after != 32'd0))   state_nxt = LOAD;
            end
            DRAIN: if (ser_empty) state_nxt = DONE;
            DONE:  begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_key     <= '0;
            o_non     <= '0;
            o_len_pt  <= '0;
            rem_bytes <= '0;
            o_pt      <= '0;
            wcnt      <= '0;
            o_otk     <= '0;
            ser_buf   <= '0;
            ser_words <= '0;
            ser_bytes <= '0;
            ser_final <= 1'b0;
        end else begin
            if (state == IDLE && i_start) begin
                o_key     <= i_key;
                o_non     <= i_non;
                o_len_pt  <= i_len;
                rem_bytes <= i_len;
                o_pt      <= '0;
                wcnt      <= '0;
            end
            if (state == OTK && eng_evt)
                o_otk <= i_ct[511:256];

            if (enter_load) begin
                o_pt <= '0;
                wcnt <= '0;
            end else if (in_xfer) begin
                for (int k = 0; k < 16; k++)
                    if (wcnt == 5'(k)) o_pt[511-32*k -: 32] <= i_data;
                wcnt <= wcnt + 5'd1;
            end

            if (ser_load) begin
                ser_buf   <= i_ct;
                ser_words <= blk_words;
                ser_bytes <= blk_bytes;
                ser_final <= (rem_after == 32'd0) || i_done;
                rem_bytes <= rem_after;
            end else if (ct_xfer) begin
                ser_buf   <= {ser_buf[479:0], 32'd0};
                ser_words <= ser_words - 5'd1;
                ser_bytes <= (ser_bytes > 7'd4) ? ser_bytes - 7'd4 : 7'd0;
            end
        end
    end
endmodule

// File: tb/tb_cc_feeder.sv
// Randomized bench for cc_feeder: a queue-based engine/sink model predicts every block
// handed to the engine and every ciphertext word, keep and last flag.
module tb_cc_feeder;
    localparam int BUDGET = 3000;

    logic         i_clk, i_rstn, i_start, i_valid, i_rqst_pt, i_done, i_ct_ready;
    logic [255:0] i_key;
    logic [95:0]  i_non;
    logic [31:0]  i_len, i_data;
    logic [511:0] i_ct;
    logic         o_ready, o_start, o_en_pt, o_ct_valid, o_ct_last, o_busy, o_done;
    logic [255:0] o_key, o_otk;
    logic [95:0]  o_non;
    logic [511:0] o_pt;
    logic [31:0]  o_len_pt, o_ct_data;
    logic [3:0]   o_ct_keep;

    int checks = 0;
    int failures = 0;

    logic [31:0]  m_len;
    int           m_nw, m_nblk;
    logic [255:0] m_key;
    logic [95:0]  m_non;
    logic [31:0]  pt_q[$];
    logic [31:0]  exp_ct[$];

    cc_feeder dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_key(i_key), .i_non(i_non),
        .i_len(i_len), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_start(o_start), .o_en_pt(o_en_pt), .o_key(o_key), .o_non(o_non), .o_pt(o_pt),
        .o_len_pt(o_len_pt), .i_rqst_pt(i_rqst_pt), .i_done(i_done), .i_ct(i_ct),
        .o_otk(o_otk), .o_ct_valid(o_ct_valid), .o_ct_data(o_ct_data),
        .o_ct_last(o_ct_last), .o_ct_keep(o_ct_keep), .i_ct_ready(i_ct_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic eng_pulse(input bit rq, input bit dn, input logic [511:0] ct);
        i_rqst_pt = rq; i_done = dn; i_ct = ct;
        @(posedge i_clk); #1;
        i_rqst_pt = 1'b0; i_done = 1'b0; i_ct = rnd512();
    endtask

    // Engine model: answers o_start with the OTK block, each o_en_pt with a random ct block
    task automatic eng();
        int cyc, idx, nwb, mode;
        logic [511:0] ct, expb;
        cyc = 0;
        do begin @(posedge i_clk); #1; cyc++; end while (!o_start && cyc < BUDGET);
        if (!o_start) begin chk("start_timeout", 0, 1); return; end
        chk("start_pt", o_pt, 0);
        chk("start_len", o_len_pt, m_len);
        chk("start_key", o_key, m_key);
        chk("start_non", o_non, m_non);
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
        #1;
        ct = rnd512();
        eng_pulse(1'b1, 1'b0, ct);
        chk("otk", o_otk, ct[511:256]);
        if (m_len == 0) chk("done_after_otk", o_done, 1);
        for (int b = 0; b < m_nblk; b++) begin
            cyc = 0;
            do begin @(posedge i_clk); #1; cyc++; end while (!o_en_pt && cyc < BUDGET);
            if (!o_en_pt) begin chk("en_timeout", 0, 1); return; end
            expb = '0;
            for (int k = 0; k < 16; k++) begin
                idx = 16 * b + k;
                if (idx < m_nw) expb[511-32*k -: 32] = pt_q[idx];
            end
            chk("blk_pt", o_pt, expb);
            chk("en_ser_empty", o_ct_valid, 0);
            repeat ($urandom_range(1, 3)) @(posedge i_clk);
            #1;
            ct = rnd512();
            nwb = (m_nw - 16 * b > 16) ? 16 : m_nw - 16 * b;
            for (int k = 0; k < nwb; k++) exp_ct.push_back(ct[511-32*k -: 32]);
            if (b < m_nblk - 1) eng_pulse(1'b1, 1'b0, ct);
            else begin
                mode = $urandom_range(0, 2);
                if (mode == 0) eng_pulse(1'b0, 1'b1, ct);
                else if (mode == 2) eng_pulse(1'b1, 1'b1, ct);
                else begin
                    eng_pulse(1'b1, 1'b0, ct);
                    repeat (2) @(posedge i_clk);
                    #1;
                    eng_pulse(1'b0, 1'b1, rnd512());
                end
            end
        end
    endtask

    task automatic src();
        int idx, cyc;
        bit v, xfer;
        idx = 0; cyc = 0; xfer = 0;
        while (idx < m_nw && cyc < BUDGET) begin
            @(posedge i_clk); #1; cyc++;
            if (xfer) idx++;
            xfer = 0;
            if (idx < m_nw) begin
                v = ($urandom_range(0, 3) != 0);
                i_valid = v; i_data = pt_q[idx];
                xfer = v && o_ready;
            end
        end
        i_valid = 1'b0;
        if (idx < m_nw) chk("pt_timeout", idx, m_nw);
    endtask

    task automatic snk(input int stall_w);
        int got, cyc, stall_cnt, lb;
        bit stalled_done, prev_stall, r, last;
        logic [31:0] prev_data, exp_d;
        logic [3:0] exp_k;
        got = 0; cyc = 0; stall_cnt = 0; stalled_done = 0; prev_stall = 0; prev_data = '0;
        while (got < m_nw && cyc < BUDGET) begin
            @(posedge i_clk); #1; cyc++;
            if (prev_stall) begin
                chk("hold_valid", o_ct_valid, 1);
                chk("hold_data", o_ct_data, prev_data);
            end
            if (o_ct_valid && got == stall_w && !stalled_done) begin
                stall_cnt = 40; stalled_done = 1;
            end
            if (stall_cnt > 0) begin r = 0; stall_cnt--; end
            else r = ($urandom_range(0, 3) != 0);
            i_ct_ready = r;
            prev_stall = o_ct_valid && !r;
            prev_data  = o_ct_data;
            if (o_ct_valid && r) begin
                last = (got == m_nw - 1);
                lb = int'(m_len) - 4 * (m_nw - 1);
                exp_k = last ? ~(4'hF >> lb) : 4'hF;
                if (exp_ct.size() == 0) chk("ct_unexpected", 1, 0);
                else begin
                    exp_d = exp_ct.pop_front();
                    chk("ct_data", o_ct_data, exp_d);
                end
                chk("ct_keep", o_ct_keep, exp_k);
                chk("ct_last", o_ct_last, last);
                got++;
            end
        end
        i_ct_ready = 1'b1;
        if (got < m_nw) chk("ct_timeout", got, m_nw);
    endtask

    task automatic watch(input bit restart);
        int cyc, nstart;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_key = m_key; i_non = m_non; i_len = m_len;
        nstart = 0; cyc = 0;
        do begin
            @(posedge i_clk); #1; cyc++;
            i_start = 1'b0;
            if (o_start) nstart++;
            if (restart && cyc == 15) begin
                i_start = 1'b1; i_key = ~m_key; i_len = m_len + 32'd5;
            end
        end while (!o_done && cyc < BUDGET);
        chk("done_seen", o_done, 1);
        chk("start_count", nstart, 1);
        chk("busy_at_done", o_busy, 1);
        chk("key_held", o_key, m_key);
        chk("len_held", o_len_pt, m_len);
        @(posedge i_clk); #1;
        chk("done_pulse", o_done, 0);
        chk("idle_busy", o_busy, 0);
        chk("idle_ct_valid", o_ct_valid, 0);
    endtask

    task automatic setup_msg(input logic [31:0] len, input bit seq);
        logic [511:0] t;
        m_len = len;
        m_nw = (int'(len) + 3) / 4;
        m_nblk = (int'(len) + 63) / 64;
        t = rnd512(); m_key = t[255:0];
        t = rnd512(); m_non = t[95:0];
        pt_q.delete();
        exp_ct.delete();
        for (int i = 0; i < m_nw; i++) pt_q.push_back(seq ? 32'(i) : $urandom);
    endtask

    task automatic run_msg(input logic [31:0] len, input int stall_w, input bit seq, input bit restart);
        setup_msg(len, seq);
        fork
            eng();
            src();
            snk(stall_w);
            watch(restart);
        join
        chk("ct_leftover", exp_ct.size(), 0);
    endtask

    // Runs a message up to its first WAIT, then resets mid-flight
    task automatic abort_msg(input logic [31:0] len);
        int cyc, noise;
        logic [511:0] t;
        t = rnd512(); m_key = t[255:0];
        @(posedge i_clk); #1;
        i_start = 1'b1; i_key = m_key; i_non = t[351:256]; i_len = len;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("ab_start", o_start, 1);
        chk("ab_len", o_len_pt, len);
        @(posedge i_clk); #1;
        eng_pulse(1'b1, 1'b0, rnd512());
        for (int k = 0; k < 16; k++) begin
            i_valid = 1'b1; i_data = $urandom; cyc = 0;
            while (!o_ready && cyc < 100) begin @(posedge i_clk); #1; cyc++; end
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        chk("ab_ready_full", o_ready, 0);
        cyc = 0;
        while (!o_en_pt && cyc < 100) begin @(posedge i_clk); #1; cyc++; end
        chk("ab_en", o_en_pt, 1);
        @(posedge i_clk); #1;
        chk("ab_busy", o_busy, 1);
        i_rstn = 1'b0;
        #1;
        chk("ab_rst_busy", o_busy, 0);
        chk("ab_rst_pt", o_pt, 0);
        chk("ab_rst_otk", o_otk, 0);
        chk("ab_rst_key", o_key, 0);
        chk("ab_rst_len", o_len_pt, 0);
        chk("ab_rst_outs", {o_ready, o_ct_valid, o_ct_keep, o_en_pt, o_start, o_done}, 0);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        noise = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) eng_pulse(1'b1, 1'b0, rnd512());
            else begin @(posedge i_clk); #1; end
            if (o_ct_valid || o_en_pt || o_done || o_busy) noise++;
        end
        chk("ab_quiet", noise, 0);
        chk("ab_otk_ignored", o_otk, 0);
    endtask

    initial begin
        int len, nw, sw;
        i_rstn = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
        i_rqst_pt = 1'b0; i_done = 1'b0; i_ct = '0; i_ct_ready = 1'b1;
        i_key = '0; i_non = '0; i_len = '0;
        #2 i_rstn = 1'b0;
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_pt", o_pt, 0);
        chk("rst_otk", o_otk, 0);
        chk("rst_outs", {o_ready, o_start, o_en_pt, o_ct_valid, o_ct_last, o_ct_keep, o_done}, 0);
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;

        run_msg(32'd0, -1, 1'b0, 1'b0);
        run_msg(32'd64, -1, 1'b1, 1'b0);
        run_msg(32'd70, -1, 1'b1, 1'b0);
        run_msg(32'd200, 5, 1'b0, 1'b0);
        run_msg(32'd100, -1, 1'b0, 1'b1);
        run_msg(32'd37, -1, 1'b0, 1'b0);
        abort_msg(32'd150);
        run_msg(32'd67, -1, 1'b0, 1'b0);
        abort_msg(32'hFFFF_FFFF);
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 260);
            nw = (len + 3) / 4;
            sw = ($urandom_range(0, 1) != 0) ? $urandom_range(0, nw - 1) : -1;
            run_msg(32'(len), sw, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
